// File: rtl/piso32_shifter_if.sv
// Handshake bundle for piso32_shifter: parallel word in, serial bit stream out.
interface piso32_shifter_if #(
  parameter int WIDTH = 32
);
   // A transfer happens on a rising edge where valid and ready are both high;
   // once valid is raised its payload holds until that transfer occurs.
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_ready;
   logic             sout_last;
   logic             busy;

   modport master (
      output in_data, in_valid, sout_ready,
      input  in_ready, sout, sout_valid, sout_last, busy
   );

   modport slave (
      input  in_data, in_valid, sout_ready,
      output in_ready, sout, sout_valid, sout_last, busy
   );
endinterface

// File: rtl/piso32_shifter.sv
// Parallel-in serial-out shifter: loads one word, emits it one bit per accepted
// cycle, and can reload on the last-bit transfer for gapless back-to-back words.
module piso32_shifter #(
   parameter int WIDTH     = 32,
   parameter int MSB_FIRST = 0,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                reset,
   piso32_shifter_if.slave     bus,
   output logic                debug_state,
   output logic [CW-1:0]       debug_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shifted;
   logic             xfer;
   logic             accept;

   function automatic logic head(input logic [WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
   endfunction

   always_comb begin
      shifted = '0;
      if (MSB_FIRST != 0) shifted = {shreg[WIDTH-2:0], 1'b0};
      else                shifted = {1'b0, shreg[WIDTH-1:1]};
   end

   // sout_last is only ever high in SHIFT, so it alone marks the reload slot.
   assign bus.in_ready = reset & ((state == IDLE) | (bus.sout_last & bus.sout_ready));
   assign xfer         = bus.sout_valid & bus.sout_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign debug_state  = (state == SHIFT);
   assign debug_count  = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         shreg          <= '0;
         count          <= '0;
         bus.sout       <= 1'b0;
         bus.sout_valid <= 1'b0;
         bus.sout_last  <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state          <= SHIFT;
                  shreg          <= bus.in_data;
                  count          <= '0;
                  bus.sout       <= head(bus.in_data);
                  bus.sout_valid <= 1'b1;
                  bus.sout_last  <= 1'b0;
                  bus.busy       <= 1'b1;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  if (accept) begin
                     shreg          <= bus.in_data;
                     count          <= '0;
                     bus.sout       <= head(bus.in_data);
                     bus.sout_last  <= 1'b0;
                  end else if (bus.sout_last) begin
                     state          <= IDLE;
                     shreg          <= '0;
                     count          <= '0;
                     bus.sout       <= 1'b0;
                     bus.sout_valid <= 1'b0;
                     bus.sout_last  <= 1'b0;
                     bus.busy       <= 1'b0;
                  end else begin
                     shreg          <= shifted;
                     count          <= count + 1'b1;
                     bus.sout       <= head(shifted);
                     bus.sout_last  <= (count == CW'(WIDTH - 2));
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso32_shifter.sv
// Bench for piso32_shifter: LSB-first and MSB-first instances share one stimulus
// stream and are checked every cycle against a bit-queue model of the stream.
module tb_piso32_shifter;

   logic        clk;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        sout_ready;
   logic        st0, st1;
   logic [4:0]  cnt0, cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected bit stream per lane: entry = {last, bit}, head is on sout now.
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   // Bits actually accepted from each DUT, for word-level checks.
   logic [1:0] rx0[$];
   logic [1:0] rx1[$];

   piso32_shifter_if #(.WIDTH(32)) bus0 ();
   piso32_shifter_if #(.WIDTH(32)) bus1 ();

   assign bus0.in_data    = in_data;
   assign bus0.in_valid   = in_valid;
   assign bus0.sout_ready = sout_ready;
   assign bus1.in_data    = in_data;
   assign bus1.in_valid   = in_valid;
   assign bus1.sout_ready = sout_ready;

   piso32_shifter #(.WIDTH(32), .MSB_FIRST(0)) dut0 (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus0),
      .debug_state (st0),
      .debug_count (cnt0)
   );

   piso32_shifter #(.WIDTH(32), .MSB_FIRST(1)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus1),
      .debug_state (st1),
      .debug_count (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a word accepted while the stream is empty (or while its final bit
   // is being taken) appends all 32 bits in transmit order.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q0.delete();
         q1.delete();
      end else begin
         logic take0, take1;
         take0 = (q0.size() == 0) || (q0.size() == 1 && sout_ready);
         take1 = (q1.size() == 0) || (q1.size() == 1 && sout_ready);
         if (q0.size() > 0 && sout_ready) void'(q0.pop_front());
         if (q1.size() > 0 && sout_ready) void'(q1.pop_front());
         if (in_valid && take0)
            for (int i = 0; i < 32; i++) q0.push_back({(i == 31), in_data[i]});
         if (in_valid && take1)
            for (int i = 0; i < 32; i++) q1.push_back({(i == 31), in_data[31-i]});
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_lane(input string ln, input int qs, input logic [1:0] hd,
                             input logic sv, input logic so, input logic sl,
                             input logic bz, input logic ir, input logic st,
                             input logic [4:0] cnt);
      logic ev;
      ev = (qs > 0);
      check({ln, "_sout_valid"}, sv, ev);
      check({ln, "_sout"},       so, ev ? hd[0] : 1'b0);
      check({ln, "_sout_last"},  sl, ev ? hd[1] : 1'b0);
      check({ln, "_busy"},       bz, ev);
      check({ln, "_in_ready"},   ir, !ev || (qs == 1 && sout_ready));
      check({ln, "_state"},      st, ev);
      check({ln, "_count"},      cnt, ev ? 5'(32 - qs) : 5'd0);
   endtask

   // One compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("rst0_outs", {bus0.sout, bus0.sout_valid, bus0.sout_last, bus0.busy, bus0.in_ready}, 0);
            check("rst1_outs", {bus1.sout, bus1.sout_valid, bus1.sout_last, bus1.busy, bus1.in_ready}, 0);
         end else begin
            check_lane("lsb", q0.size(), (q0.size() > 0) ? q0[0] : 2'b00, bus0.sout_valid,
                       bus0.sout, bus0.sout_last, bus0.busy, bus0.in_ready, st0, cnt0);
            check_lane("msb", q1.size(), (q1.size() > 0) ? q1[0] : 2'b00, bus1.sout_valid,
                       bus1.sout, bus1.sout_last, bus1.busy, bus1.in_ready, st1, cnt1);
            if (bus0.sout_valid && sout_ready) rx0.push_back({bus0.sout_last, bus0.sout});
            if (bus1.sout_valid && sout_ready) rx1.push_back({bus1.sout_last, bus1.sout});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Rebuild a word from 32 received bits starting at s, in the lane's bit order.
   task automatic pack(input int lane, input int s, output logic [31:0] w,
                       output int nlast, output int lastpos);
      logic [1:0] e;
      w = 'x;
      nlast = 0;
      lastpos = -1;
      for (int i = 0; i < 32; i++) begin
         e = 2'bxx;
         if (lane == 0 && s + i < rx0.size()) e = rx0[s+i];
         if (lane == 1 && s + i < rx1.size()) e = rx1[s+i];
         w[(lane == 0) ? i : 31 - i] = e[0];
         if (e[1] === 1'b1) begin
            nlast++;
            lastpos = i;
         end
      end
   endtask

   task automatic check_word(input string nm, input int s, input logic [31:0] exp);
      logic [31:0] w;
      int nl, lp;
      pack(0, s, w, nl, lp);
      check({nm, "_lsb_word"}, w, exp);
      check({nm, "_lsb_nlast"}, nl, 1);
      check({nm, "_lsb_lastpos"}, lp, 31);
      pack(1, s, w, nl, lp);
      check({nm, "_msb_word"}, w, exp);
      check({nm, "_msb_nlast"}, nl, 1);
      check({nm, "_msb_lastpos"}, lp, 31);
   endtask

   initial begin
      int s, s_pre, nl;
      logic [7:0] first8;
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      sout_ready = 1'b1;
      #2 reset = 1'b0;
      cyc(3);
      @(negedge clk);
      check("reset_in_ready", bus0.in_ready, 0);
      check("reset_count", cnt0, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("release_in_ready", bus0.in_ready, 1);

      // Single word, both bit orders.
      @(posedge clk); #1;
      s = rx0.size();
      in_valid = 1'b1; in_data = 32'hA5A50F01;
      cyc(1); in_valid = 1'b0;
      cyc(35);
      check("w1_count_lsb", rx0.size() - s, 32);
      check("w1_count_msb", rx1.size() - s, 32);
      check_word("w1", s, 32'hA5A50F01);
      for (int i = 0; i < 8; i++) first8[7-i] = rx1[s+i][0];
      check("w1_msb_first8", first8, 8'hA5);
      for (int i = 0; i < 8; i++) first8[i] = rx0[s+i][0];
      check("w1_lsb_first8", first8, 8'h01);
      @(negedge clk);
      check("w1_idle_in_ready", bus0.in_ready, 1);

      // Backpressure at bit 5 and at the last bit.
      @(posedge clk); #1;
      s = rx0.size();
      in_valid = 1'b1; in_data = 32'hC3A500E1;
      cyc(1); in_valid = 1'b0;
      cyc(5); sout_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall5_count", cnt0, 5);
         check("stall5_sout", bus0.sout, 1);
         check("stall5_last", bus0.sout_last, 0);
         @(posedge clk); #1;
      end
      sout_ready = 1'b1;
      cyc(26); sout_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("stall31_count", cnt0, 31);
         check("stall31_sout", bus0.sout, 1);
         check("stall31_last", bus0.sout_last, 1);
         check("stall31_in_ready", bus0.in_ready, 0);
         check("stall31_msb_sout", bus1.sout, 1);
         @(posedge clk); #1;
      end
      sout_ready = 1'b1;
      cyc(3);
      check("bp_count", rx0.size() - s, 32);
      check_word("bp", s, 32'hC3A500E1);

      // Back-to-back: second word taken in the last-bit transfer cycle.
      @(posedge clk); #1;
      s = rx0.size();
      in_valid = 1'b1; in_data = 32'hFFFFFFFF;
      cyc(1); in_data = 32'h00000000;
      cyc(31);
      @(negedge clk);
      check("b2b_in_ready", bus0.in_ready, 1);
      check("b2b_last", bus0.sout_last, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      cyc(34);
      check("b2b_count", rx0.size() - s, 64);
      check_word("b2b_w0", s, 32'hFFFFFFFF);
      check_word("b2b_w1", s + 32, 32'h00000000);

      // Ignored in_valid pulse mid-word.
      @(posedge clk); #1;
      s = rx0.size();
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      cyc(1); in_valid = 1'b0;
      cyc(10);
      in_valid = 1'b1; in_data = 32'h12345678;
      @(negedge clk);
      check("ign_in_ready", bus0.in_ready, 0);
      check("ign_count", cnt0, 10);
      @(posedge clk); #1 in_valid = 1'b0;
      cyc(30);
      check("ign_total", rx0.size() - s, 32);
      check_word("ign", s, 32'hDEADBEEF);
      @(negedge clk);
      check("ign_no_second", bus0.sout_valid, 0);

      // Reset in the middle of a word.
      @(posedge clk); #1;
      s_pre = rx0.size();
      in_valid = 1'b1; in_data = 32'hFFFFFFFF;
      cyc(1); in_valid = 1'b0;
      cyc(12);
      #2 reset = 1'b0;
      #1;
      check("midrst_sout_valid", bus0.sout_valid, 0);
      check("midrst_busy", bus0.busy, 0);
      check("midrst_sout", bus0.sout, 0);
      check("midrst_in_ready", bus0.in_ready, 0);
      check("midrst_count", cnt0, 0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_release_in_ready", bus0.in_ready, 1);
      s = rx0.size();
      check("midrst_partial_bits", s - s_pre, 12);
      nl = 0;
      for (int i = s_pre; i < s; i++) nl += int'(rx0[i][1]);
      check("midrst_no_last", nl, 0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'h00000003;
      cyc(1); in_valid = 1'b0;
      cyc(35);
      check("after_rst_bit0", rx0[s][0], 1);
      check("after_rst_bit1", rx0[s+1][0], 1);
      check("after_rst_bit2", rx0[s+2][0], 0);
      check_word("after_rst", s, 32'h00000003);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/piso32_shifter.md
Name: piso32_shifter

Overview:
- Parallel-in, serial-out shifter that converts a WIDTH-bit parallel word into a serial stream.
- It is the transmit-side counterpart of the team's parallel capture registers: a 32-bit word is loaded in one cycle and shifted out one bit per accepted cycle.
- Sits between a 32-bit datapath register and a serial link or downstream deserializer.
- Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 0, 0 = bit 0 is transmitted first; 1 = bit WIDTH-1 is transmitted first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- sout_ready  input  1  downstream accepts sout this cycle.
- sout_last  output  1  sout is the final bit of the current word.
- busy  output  1  a word is in flight (SHIFT state).

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - in_ready = 0 while reset is low.
  - sout = 0, sout_valid = 0, sout_last = 0, busy = 0.
- After reset release: in_ready = 1 from the first cycle.
- States:
  - IDLE: in_ready = 1, sout_valid = 0, sout = 0.
    - On in_valid & in_ready: load in_data into the shift register, counter = 0, go to SHIFT.
    - First bit is presented in the next cycle (1-cycle load latency).
  - SHIFT: busy = 1, sout_valid = 1.
    - sout = shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
    - sout_last = 1 iff counter == WIDTH-1.
    - Bit transfer happens when sout_valid & sout_ready. On transfer: shift by one toward the output end, zero-fill, counter + 1.
    - When sout_ready = 0: shift register, counter and all outputs hold. sout must stay stable until accepted.
    - Transfer of the last bit with no new word accepted: go to IDLE next cycle.
- Back-to-back:
  - in_ready = IDLE | (SHIFT & sout_last & sout_ready).
  - If a new word is accepted in the last-bit transfer cycle: reload, counter = 0, stay in SHIFT.
  - Result: zero gap cycles; bit 0 of word N+1 follows the last bit of word N directly.
- in_valid while busy and not in the last-bit transfer cycle: ignored. in_data is not sampled and in_ready = 0.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1; no wrap beyond the word.
- Full word throughput: WIDTH transfer cycles plus 1 load cycle when starting from IDLE.
- Reset asserted mid-word:
  - Word is discarded immediately (asynchronous).
  - Outputs return to reset values.
  - No partial sout_last is issued.

Test Plan:
- Reset, then load 0xA5A50F01, MSB_FIRST=0, sout_ready tied 1:
  - Load cycle, then 32 consecutive sout_valid cycles.
  - Bits in order: 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1.
  - sout_last only on bit 32; back in IDLE with in_ready = 1 the next cycle.
- Same word with MSB_FIRST=1:
  - First bits 1,0,1,0,0,1,0,1; last bit 1.
  - Deserialized stream equals 0xA5A50F01.
- Backpressure: hold sout_ready = 0 for 3 cycles at bit index 5 and 4 cycles at bit 31.
  - sout, sout_last and counter hold during each stall.
  - Total transfer count is exactly 32; no bit duplicated or lost.
- Back-to-back: words 0xFFFFFFFF then 0x00000000, in_valid held high.
  - Second word accepted in the sout_last transfer cycle.
  - 64 contiguous sout_valid cycles: 32 ones then 32 zeros.
  - sout_last pulses at transfers 32 and 64.
- Ignored input: pulse in_valid with 0x12345678 at bit index 10 of word 0xDEADBEEF.
  - in_ready = 0 at that point.
  - Serial output is exactly 0xDEADBEEF and no second word follows.
- Reset mid-word: assert reset at bit index 12, release after 2 cycles.
  - sout_valid = 0, busy = 0, sout = 0 immediately.
  - in_ready = 1 after release.
  - Next word 0x0000_0003 shifts out cleanly starting with bits 1,1,0.
